fir_mul_pipe: RTL and testbench



---
 rtl/fir_mul_pipe.sv | 144 ++++++++++++++
 tb/tb_fir_mul_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mul_pipe.sv
// Two-stage pipelined posit multiplier in fields-intermediate form.
// Stage 1 forms the raw sign/exponent/product; stage 2 normalizes and forces specials to zero payload.
module fir_mul_pipe #(
   parameter int N         = 16,
   parameter int ES        = 1,
   parameter int TE_SIZE   = ES + $clog2(N) + 1,
   parameter int MANT_SIZE = N - 2,
   parameter int FIR_SIZE  = 1 + TE_SIZE + MANT_SIZE
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [FIR_SIZE-1:0]      fir_a,
   input  logic [FIR_SIZE-1:0]      fir_b,
   input  logic                     zero_a,
   input  logic                     zero_b,
   input  logic                     nar_a,
   input  logic                     nar_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     sign_out,
   output logic [TE_SIZE:0]         te_out,
   output logic [2*MANT_SIZE-1:0]   mant_out,
   output logic                     zero_out,
   output logic                     nar_out
);

   localparam int PW = 2 * MANT_SIZE;

   logic                 sign_a_s, sign_b_s;
   logic [TE_SIZE-1:0]   te_a_s, te_b_s;
   logic [MANT_SIZE-1:0] mant_a_s, mant_b_s;
   logic [TE_SIZE:0]     s1_te_s;
   logic [PW-1:0]        s1_prod_s;
   logic                 s1_nar_s, s1_zero_s;
   logic                 s1_en_s, s2_en_s;

   logic                 s1_valid_r;
   logic                 s1_sign_r;
   logic [TE_SIZE:0]     s1_te_r;
   logic [PW-1:0]        s1_prod_r;
   logic                 s1_zero_r, s1_nar_r;

   logic                 s2_sign_s;
   logic [TE_SIZE:0]     s2_te_s;
   logic [PW-1:0]        s2_mant_s;

   assign sign_a_s = fir_a[FIR_SIZE-1];
   assign sign_b_s = fir_b[FIR_SIZE-1];
   assign te_a_s   = fir_a[FIR_SIZE-2 -: TE_SIZE];
   assign te_b_s   = fir_b[FIR_SIZE-2 -: TE_SIZE];
   assign mant_a_s = fir_a[MANT_SIZE-1:0];
   assign mant_b_s = fir_b[MANT_SIZE-1:0];

   assign s1_te_s   = {te_a_s[TE_SIZE-1], te_a_s} + {te_b_s[TE_SIZE-1], te_b_s};
   assign s1_prod_s = {{MANT_SIZE{1'b0}}, mant_a_s} * {{MANT_SIZE{1'b0}}, mant_b_s};
   assign s1_nar_s  = nar_a | nar_b;
   assign s1_zero_s = !s1_nar_s & (zero_a | zero_b);

   // A stage may load when it is empty or its contents leave this cycle.
   assign s2_en_s  = !out_valid | out_ready;
   assign s1_en_s  = !s1_valid_r | s2_en_s;
   assign in_ready = s1_en_s;

   // Stage 1 occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
      end else if (s1_en_s) begin
         s1_valid_r <= in_valid;
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   // Stage 1 payload, loaded only on an input transfer.
   always_ff @(posedge clk) begin
      if (in_valid && s1_en_s) begin
         s1_sign_r <= sign_a_s ^ sign_b_s;
         s1_te_r   <= s1_te_s;
         s1_prod_r <= s1_prod_s;
         s1_zero_r <= s1_zero_s;
         s1_nar_r  <= s1_nar_s;
      end else begin
         s1_sign_r <= s1_sign_r;
         s1_te_r   <= s1_te_r;
         s1_prod_r <= s1_prod_r;
         s1_zero_r <= s1_zero_r;
         s1_nar_r  <= s1_nar_r;
      end
   end

   // Normalize the product so its MSB is the hidden bit; specials carry an all-zero payload.
   always_comb begin
      s2_sign_s = s1_sign_r;
      s2_te_s   = s1_te_r;
      s2_mant_s = s1_prod_r;
      if (s1_nar_r || s1_zero_r) begin
         s2_sign_s = 1'b0;
         s2_te_s   = {(TE_SIZE+1){1'b0}};
         s2_mant_s = {PW{1'b0}};
      end else if (s1_prod_r[PW-1]) begin
         s2_te_s   = s1_te_r + {{TE_SIZE{1'b0}}, 1'b1};
      end else begin
         s2_mant_s = {s1_prod_r[PW-2:0], 1'b0};
      end
   end

   // Stage 2 doubles as the output register and holds until the output transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sign_out  <= 1'b0;
         te_out    <= {(TE_SIZE+1){1'b0}};
         mant_out  <= {PW{1'b0}};
         zero_out  <= 1'b0;
         nar_out   <= 1'b0;
      end else if (s2_en_s) begin
         out_valid <= s1_valid_r;
         if (s1_valid_r) begin
            sign_out <= s2_sign_s;
            te_out   <= s2_te_s;
            mant_out <= s2_mant_s;
            zero_out <= s1_zero_r;
            nar_out  <= s1_nar_r;
         end else begin
            sign_out <= sign_out;
            te_out   <= te_out;
            mant_out <= mant_out;
            zero_out <= zero_out;
            nar_out  <= nar_out;
         end
      end else begin
         out_valid <= out_valid;
         sign_out  <= sign_out;
         te_out    <= te_out;
         mant_out  <= mant_out;
         zero_out  <= zero_out;
         nar_out   <= nar_out;
      end
   end

endmodule

// File: tb/tb_fir_mul_pipe.sv
// Bench for fir_mul_pipe: hand-computed vector table, stall/bubble/reset sequences
// and a randomized run, all checked by an in-order expectation queue.
module tb_fir_mul_pipe;

   typedef struct {
      logic [20:0] fa;
      logic [20:0] fb;
      logic [3:0]  fl;   // {zero_a, zero_b, nar_a, nar_b}
      logic [37:0] exp;  // {sign, te[6:0], mant[27:0], zero, nar}
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [20:0] fir_a, fir_b;
   logic        zero_a, zero_b, nar_a, nar_b;
   logic        sign_out, zero_out, nar_out;
   logic [6:0]  te_out;
   logic [27:0] mant_out;
   logic [37:0] got_s;
   logic [37:0] cur_exp;
   logic [37:0] exp_q[$];
   vec_t        tbl[8];
   int          total = 0;
   int          bad = 0;
   logic        acc;

   always #5 clk = ~clk;

   fir_mul_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .fir_a(fir_a), .fir_b(fir_b), .zero_a(zero_a), .zero_b(zero_b),
      .nar_a(nar_a), .nar_b(nar_b), .out_valid(out_valid), .out_ready(out_ready),
      .sign_out(sign_out), .te_out(te_out), .mant_out(mant_out),
      .zero_out(zero_out), .nar_out(nar_out)
   );

   assign got_s = {sign_out, te_out, mant_out, zero_out, nar_out};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic logic [20:0] mk(input logic s, input int te, input int m);
      return {s, 6'(te), 14'(m)};
   endfunction

   function automatic logic [37:0] res(input logic s, input int te, input int m, input logic z, input logic n);
      return {s, 7'(te), 28'(m), z, n};
   endfunction

   // Reference: arithmetic on plain integers.
   function automatic logic [37:0] model(input logic [20:0] fa, input logic [20:0] fb, input logic [3:0] fl);
      int     t;
      longint p;
      logic [63:0] pv;
      if (fl[1] || fl[0]) return res(1'b0, 0, 0, 1'b0, 1'b1);
      if (fl[3] || fl[2]) return res(1'b0, 0, 0, 1'b1, 1'b0);
      t = int'($signed(fa[19:14])) + int'($signed(fb[19:14]));
      p = longint'(fa[13:0]) * longint'(fb[13:0]);
      if (p >= 64'sd134217728) t = t + 1;
      else p = p * 2;
      pv = 64'(p);
      return {fa[20] ^ fb[20], 7'(t), pv[27:0], 2'b00};
   endfunction

   // Scoreboard: every visible output must equal the oldest accepted expectation.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", 64'd1, 64'd0);
            end else begin
               chk("out_data", 64'(got_s), 64'(exp_q[0]));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back(cur_exp);
      end
   end

   // Drive one cycle starting just after a rising edge; acc reports the input transfer.
   task automatic step(input logic v, input logic [20:0] fa, input logic [20:0] fb, input logic [3:0] fl,
                       input logic [37:0] e, input logic ordy, output logic a);
      in_valid = v; fir_a = fa; fir_b = fb;
      {zero_a, zero_b, nar_a, nar_b} = fl;
      cur_exp = e; out_ready = ordy;
      @(negedge clk);
      a = v & in_ready;
      @(posedge clk);
      #1;
   endtask

   // rmode: 0 = out_ready low, 1 = high, 2 = random per cycle.
   task automatic send(input logic [20:0] fa, input logic [20:0] fb, input logic [3:0] fl,
                       input logic [37:0] e, input int rmode);
      logic a = 1'b0;
      for (int i = 0; i < 200 && !a; i++) begin
         step(1'b1, fa, fb, fl, e, (rmode == 2) ? ($urandom_range(0, 3) != 0) : (rmode == 1), a);
      end
      if (!a) chk("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n, input logic ordy);
      logic a;
      for (int i = 0; i < n; i++) step(1'b0, 21'd0, 21'd0, 4'd0, 38'd0, ordy, a);
   endtask

   task automatic drain;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1, 1'b1);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      idle(1, 1'b1);
   endtask

   initial begin
      tbl[0] = '{mk(1'b0, 0, 'h3000),   mk(1'b0, 0, 'h3000),   4'b0000, res(1'b0, 1, 'h9000000, 1'b0, 1'b0)};
      tbl[1] = '{mk(1'b0, 3, 'h2000),   mk(1'b1, -5, 'h2000),  4'b0000, res(1'b1, -2, 'h8000000, 1'b0, 1'b0)};
      tbl[2] = '{mk(1'b1, 4, 'h2abc),   mk(1'b0, 1, 'h3000),   4'b0110, res(1'b0, 0, 0, 1'b0, 1'b1)};
      tbl[3] = '{mk(1'b1, 7, 'h1234),   mk(1'b0, 2, 'h3000),   4'b1000, res(1'b0, 0, 0, 1'b1, 1'b0)};
      tbl[4] = '{mk(1'b1, 15, 'h3fff),  mk(1'b1, 15, 'h3fff),  4'b0000, res(1'b0, 31, 'hfff8001, 1'b0, 1'b0)};
      tbl[5] = '{mk(1'b1, -32, 'h2000), mk(1'b0, -32, 'h2000), 4'b0000, res(1'b1, -64, 'h8000000, 1'b0, 1'b0)};
      tbl[6] = '{mk(1'b0, 5, 'h2000),   mk(1'b0, -2, 'h3fff),  4'b0000, res(1'b0, 3, 'hfffc000, 1'b0, 1'b0)};
      tbl[7] = '{mk(1'b0, 1, 'h2000),   mk(1'b1, 1, 'h2400),   4'b0001, res(1'b0, 0, 0, 1'b0, 1'b1)};

      in_valid = 1'b0; out_ready = 1'b0; fir_a = 21'd0; fir_b = 21'd0;
      zero_a = 1'b0; zero_b = 1'b0; nar_a = 1'b0; nar_b = 1'b0; cur_exp = 38'd0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_payload", 64'(got_s), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Table: each vector alone, with a latency check.
      for (int i = 0; i < 8; i++) begin
         send(tbl[i].fa, tbl[i].fb, tbl[i].fl, tbl[i].exp, 1);
         idle(1, 1'b1);
         chk($sformatf("latency_v%0d", i), 64'(out_valid), 64'd1);
         idle(1, 1'b1);
      end
      chk("table_drained", 64'(exp_q.size()), 64'd0);

      // Stall fill: 4 back-to-back offers against a blocked output.
      begin
         int j = 0;
         int k [4] = '{0, 1, 4, 6};
         for (int c = 0; c < 4; c++) begin
            step(1'b1, tbl[k[j]].fa, tbl[k[j]].fb, tbl[k[j]].fl, tbl[k[j]].exp, 1'b0, acc);
            if (acc) j++;
         end
         chk("stall_accepts", 64'(j), 64'd2);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         for (int c = 0; c < 3; c++) begin
            step(1'b1, tbl[k[j]].fa, tbl[k[j]].fb, tbl[k[j]].fl, tbl[k[j]].exp, 1'b0, acc);
            if (acc) j++;
         end
         chk("stall_hold_accepts", 64'(j), 64'd2);
         out_ready = 1'b1;
         #1 chk("release_in_ready", 64'(in_ready), 64'd1);
         for (int c = 0; c < 20 && j < 4; c++) begin
            step(1'b1, tbl[k[j]].fa, tbl[k[j]].fb, tbl[k[j]].fl, tbl[k[j]].exp, 1'b1, acc);
            if (acc) j++;
         end
         in_valid = 1'b0;
         chk("release_accepts", 64'(j), 64'd4);
         drain();
      end

      // Bubble collapse: A parks in S2, B must still enter S1.
      send(tbl[0].fa, tbl[0].fb, tbl[0].fl, tbl[0].exp, 0);
      idle(3, 1'b0);
      step(1'b1, tbl[5].fa, tbl[5].fb, tbl[5].fl, tbl[5].exp, 1'b0, acc);
      chk("bubble_accept", 64'(acc), 64'd1);
      chk("bubble_full_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      drain();

      // Reset with both stages full.
      send(tbl[4].fa, tbl[4].fb, tbl[4].fl, tbl[4].exp, 0);
      send(tbl[6].fa, tbl[6].fb, tbl[6].fl, tbl[6].exp, 0);
      chk("pre_reset_full", 64'({out_valid, in_ready}), 64'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", 64'(out_valid), 64'd0);
      chk("midreset_in_ready", 64'(in_ready), 64'd1);
      chk("midreset_payload", 64'(got_s), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(4, 1'b1);
      chk("post_reset_idle", 64'(out_valid), 64'd0);
      send(tbl[1].fa, tbl[1].fb, tbl[1].fl, tbl[1].exp, 1);
      idle(1, 1'b1);
      chk("post_reset_latency", 64'(out_valid), 64'd1);
      chk("post_reset_data", 64'(got_s), 64'(tbl[1].exp));
      drain();

      // Random operands, random gaps and random backpressure.
      for (int n = 0; n < 10000; n++) begin
         logic [20:0] fa, fb;
         logic [3:0]  fl;
         int r;
         fa = {1'($urandom), 6'($urandom_range(0, 63)), 1'b1, 13'($urandom)};
         fb = {1'($urandom), 6'($urandom_range(0, 63)), 1'b1, 13'($urandom)};
         r  = $urandom_range(0, 15);
         fl = (r == 0) ? 4'b0010 : (r == 1) ? 4'b0001 : (r == 2) ? 4'b1000 : (r == 3) ? 4'b0100 : 4'b0000;
         if ($urandom_range(0, 3) == 0) idle(1, 1'($urandom_range(0, 1)));
         send(fa, fb, fl, model(fa, fb, fl), 2);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
